// File: rtl/multi_session_manager.sv
// Per-host FIX session sequencing with heartbeat timers, prioritised event intake
// and a small outbound request FIFO feeding create_message.
module multi_session_manager #(
  parameter int HOST_AW   = 3,
  parameter int HB_CYCLES = 1000,
  parameter int REQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               connected_i,
  input  logic [HOST_AW-1:0] connected_host_i,
  input  logic               initiator_i,
  input  logic               new_message_i,
  input  logic [HOST_AW-1:0] msg_host_i,
  input  logic [3:0]         type_i,
  input  logic [3:0]         validity_i,
  input  logic               end_session_i,
  input  logic [HOST_AW-1:0] end_host_i,
  input  logic               resend_done_i,
  input  logic [HOST_AW-1:0] resend_done_host_i,
  output logic               conn_ready_o,
  output logic               msg_ready_o,
  output logic               end_ready_o,
  output logic               done_ready_o,
  output logic               req_valid_o,
  output logic [3:0]         req_type_o,
  output logic [HOST_AW-1:0] req_host_o,
  input  logic               req_ready_i,
  output logic               disconnect_o,
  output logic [HOST_AW-1:0] disconnect_host_o,
  output logic               ignore_o,
  output logic               update_seq_o,
  output logic [HOST_AW-1:0] update_seq_host_o,
  output logic               resend_o,
  output logic [HOST_AW-1:0] resend_host_o,
  input  logic [HOST_AW-1:0] state_host_i,
  output logic [2:0]         state_o
);

  localparam int NH = 1 << HOST_AW;
  localparam int TW = $clog2(HB_CYCLES + 1);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] T_LOGON     = 4'd0;
  localparam logic [3:0] T_LOGOUT    = 4'd1;
  localparam logic [3:0] T_HEARTBEAT = 4'd2;
  localparam logic [3:0] T_RESENDREQ = 4'd3;
  localparam logic [3:0] T_GAPFILL   = 4'd4;
  localparam logic [3:0] T_RESET     = 4'd5;

  localparam logic [3:0] V_VALID   = 4'd0;
  localparam logic [3:0] V_GARBLED = 4'd1;
  localparam logic [3:0] V_SEQH    = 4'd2;
  localparam logic [3:0] V_SEQL    = 4'd3;
  localparam logic [3:0] V_INVALID = 4'd4;

  typedef enum logic [2:0] {
    S_DISC          = 3'd0,
    S_CONN          = 3'd1,
    S_LOGON_SENT    = 3'd2,
    S_NORMAL        = 3'd3,
    S_SENT_HB       = 3'd4,
    S_LOGOUT_SENT   = 3'd5,
    S_SENT_RESEND   = 3'd6,
    S_RESEND_LOGOUT = 3'd7
  } state_t;

  state_t             r_state [NH];
  logic [TW-1:0]      r_timer [NH];
  logic [NH-1:0]      r_exp;
  logic [HOST_AW-1:0] r_ptr;
  logic               r_run;
  logic [3:0]         r_fifo_type [REQ_DEPTH];
  logic [HOST_AW-1:0] r_fifo_host [REQ_DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_req_valid;
  logic               r_disc;
  logic               r_ign;
  logic               r_upd;
  logic               r_rsd;
  logic [HOST_AW-1:0] r_evt_host;
  logic [2:0]         r_state_o;

  logic               w_space;
  logic               w_acc_conn;
  logic               w_acc_msg;
  logic               w_acc_end;
  logic               w_acc_done;
  logic               w_any_acc;
  logic               w_svc;
  logic               w_touch;
  logic [HOST_AW-1:0] w_host;
  state_t             w_cur;
  state_t             w_nstate;
  logic               w_push;
  logic [3:0]         w_ptype;
  logic               w_disc;
  logic               w_ign;
  logic               w_upd;
  logic               w_rsd;
  logic               w_pop;
  logic [CW-1:0]      w_cnt_n;
  logic               w_ok;
  logic               w_seqh;
  logic               w_bad;

  // Readys need only a free slot; lower-priority sources are masked by any higher pending valid.
  assign w_space      = r_run && (r_cnt != CW'(REQ_DEPTH));
  assign conn_ready_o = w_space;
  assign msg_ready_o  = w_space & ~connected_i;
  assign end_ready_o  = w_space & ~connected_i & ~new_message_i;
  assign done_ready_o = w_space & ~connected_i & ~new_message_i & ~end_session_i;

  assign w_acc_conn = connected_i & conn_ready_o;
  assign w_acc_msg  = new_message_i & msg_ready_o;
  assign w_acc_end  = end_session_i & end_ready_o;
  assign w_acc_done = resend_done_i & done_ready_o;
  assign w_any_acc  = w_acc_conn | w_acc_msg | w_acc_end | w_acc_done;
  assign w_svc      = ~w_any_acc & w_space & r_exp[r_ptr];
  assign w_touch    = w_any_acc | w_svc;

  assign w_ok   = (validity_i == V_VALID);
  assign w_seqh = (validity_i == V_SEQH);
  assign w_bad  = (validity_i == V_SEQL) || (validity_i == V_INVALID);

  always_comb begin
    w_host = r_ptr;
    if (w_acc_conn)      w_host = connected_host_i;
    else if (w_acc_msg)  w_host = msg_host_i;
    else if (w_acc_end)  w_host = end_host_i;
    else if (w_acc_done) w_host = resend_done_host_i;
  end

  always_comb begin
    w_cur    = r_state[w_host];
    w_nstate = w_cur;
    w_push   = 1'b0;
    w_ptype  = T_HEARTBEAT;
    w_disc   = 1'b0;
    w_ign    = 1'b0;
    w_upd    = 1'b0;
    w_rsd    = 1'b0;
    if (w_acc_conn) begin
      if (initiator_i) begin
        w_push   = 1'b1;
        w_ptype  = T_LOGON;
        w_nstate = S_LOGON_SENT;
      end else begin
        w_nstate = S_CONN;
      end
    end else if (w_acc_msg) begin
      if (w_cur == S_DISC) begin
        w_ign = 1'b1;
      end else if (w_bad) begin
        w_disc   = 1'b1;
        w_nstate = S_DISC;
      end else if (validity_i == V_GARBLED) begin
        w_ign = 1'b1;
      end else begin
        case (w_cur)
          S_CONN: begin
            if (type_i == T_LOGON && w_ok) begin
              w_push   = 1'b1;
              w_ptype  = T_LOGON;
              w_nstate = S_NORMAL;
            end else begin
              w_disc   = 1'b1;
              w_nstate = S_DISC;
            end
          end
          S_LOGON_SENT: begin
            if (type_i == T_LOGON && w_ok) begin
              w_nstate = S_NORMAL;
            end else if (type_i == T_LOGON && w_seqh) begin
              w_push   = 1'b1;
              w_ptype  = T_RESENDREQ;
              w_nstate = S_SENT_RESEND;
            end else begin
              w_disc   = 1'b1;
              w_nstate = S_DISC;
            end
          end
          S_NORMAL, S_SENT_HB: begin
            if (type_i == T_LOGOUT && w_seqh) begin
              w_push   = 1'b1;
              w_ptype  = T_RESENDREQ;
              w_nstate = S_RESEND_LOGOUT;
            end else if (type_i == T_LOGOUT && w_ok) begin
              w_push   = 1'b1;
              w_ptype  = T_LOGOUT;
              w_nstate = S_DISC;
            end else if (type_i == T_RESENDREQ) begin
              w_rsd    = 1'b1;
              w_nstate = S_NORMAL;
            end else if (w_seqh) begin
              w_push   = 1'b1;
              w_ptype  = T_RESENDREQ;
              w_nstate = S_SENT_RESEND;
            end else begin
              w_nstate = S_NORMAL;
            end
          end
          S_SENT_RESEND, S_RESEND_LOGOUT: begin
            if (type_i == T_GAPFILL || type_i == T_RESET) begin
              w_upd = 1'b1;
            end else if (w_seqh) begin
              w_push  = 1'b1;
              w_ptype = T_RESENDREQ;
            end
          end
          S_LOGOUT_SENT: begin
            if (type_i == T_LOGOUT) begin
              w_disc   = 1'b1;
              w_nstate = S_DISC;
            end else begin
              w_ign = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (w_acc_end) begin
      if (w_cur == S_NORMAL || w_cur == S_SENT_HB) begin
        w_push   = 1'b1;
        w_ptype  = T_LOGOUT;
        w_nstate = S_LOGOUT_SENT;
      end
    end else if (w_acc_done) begin
      if (w_cur == S_SENT_RESEND) begin
        w_nstate = S_NORMAL;
      end else if (w_cur == S_RESEND_LOGOUT) begin
        w_push   = 1'b1;
        w_ptype  = T_LOGOUT;
        w_nstate = S_LOGOUT_SENT;
      end
    end else if (w_svc) begin
      case (w_cur)
        S_CONN, S_LOGON_SENT, S_LOGOUT_SENT, S_SENT_HB: begin
          w_disc   = 1'b1;
          w_nstate = S_DISC;
        end
        S_NORMAL: begin
          w_push   = 1'b1;
          w_nstate = S_SENT_HB;
        end
        S_SENT_RESEND, S_RESEND_LOGOUT: w_push = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_pop   = r_req_valid & req_ready_i;
  assign w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_type[r_wp] <= w_ptype;
      r_fifo_host[r_wp] <= w_host;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NH; h++) begin
        r_state[h] <= S_DISC;
        r_timer[h] <= '0;
      end
      r_exp       <= '0;
      r_ptr       <= '0;
      r_run       <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_req_valid <= 1'b0;
      r_disc      <= 1'b0;
      r_ign       <= 1'b0;
      r_upd       <= 1'b0;
      r_rsd       <= 1'b0;
      r_evt_host  <= '0;
      r_state_o   <= '0;
    end else begin
      r_run <= 1'b1;
      // Down-counter per host: reload on activity, flag expiry at terminal count and hold at 0.
      for (int h = 0; h < NH; h++) begin
        if (w_touch && (HOST_AW'(h) == w_host)) begin
          r_state[h] <= w_nstate;
          r_timer[h] <= (w_nstate == S_DISC) ? '0 : TW'(HB_CYCLES);
          r_exp[h]   <= 1'b0;
        end else if (r_state[h] == S_DISC) begin
          r_timer[h] <= '0;
          r_exp[h]   <= 1'b0;
        end else if (r_timer[h] == TW'(1)) begin
          r_timer[h] <= '0;
          r_exp[h]   <= 1'b1;
        end else if (r_timer[h] != '0) begin
          r_timer[h] <= r_timer[h] - TW'(1);
        end
      end
      if (!w_any_acc) r_ptr <= r_ptr + HOST_AW'(1);
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt       <= w_cnt_n;
      r_req_valid <= (w_cnt_n != '0);
      r_disc      <= w_disc;
      r_ign       <= w_ign;
      r_upd       <= w_upd;
      r_rsd       <= w_rsd;
      r_evt_host  <= w_host;
      r_state_o   <= r_state[state_host_i];
    end
  end

  assign req_valid_o       = r_req_valid;
  assign req_type_o        = r_fifo_type[r_rp];
  assign req_host_o        = r_fifo_host[r_rp];
  assign disconnect_o      = r_disc;
  assign disconnect_host_o = r_evt_host;
  assign ignore_o          = r_ign;
  assign update_seq_o      = r_upd;
  assign update_seq_host_o = r_evt_host;
  assign resend_o          = r_rsd;
  assign resend_host_o     = r_evt_host;
  assign state_o           = r_state_o;

endmodule

// File: doc/multi_session_manager.md
# multi_session_manager

Parametrised successor to the FIX session manager. Holds a per-host session state machine and heartbeat timer for up to 2^HOST_AW hosts, and arbitrates connect, received-message, end-session and resend-done events with valid/ready backpressure. Queues outbound message requests (logon, logout, heartbeat, resendReq) to create_message through a FIFO with a valid/ready handshake. Sits between the received-message processor/connection_toe and create_message/sequence generator.

## Interface
- HOST_AW, 3: host address width; 2^HOST_AW sessions.
- HB_CYCLES, 1000: heartbeat interval in clk cycles (≥2).
- REQ_DEPTH, 4: outbound request FIFO depth (power of 2, ≥2).
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- connected_i / connected_host_i / initiator_i  in  1/HOST_AW/1  connect event; initiator_i=1: we send logon.
- new_message_i / msg_host_i / type_i / validity_i  in  1/HOST_AW/4/4  received message (`logon, `logout, `heartbeat, `resendReq, `gapFill, `reset; `valid, `garbled, `msgSeqH, `msgSeqL, `invalid).
- end_session_i / end_host_i  in  1/HOST_AW  local logout request.
- resend_done_i / resend_done_host_i  in  1/HOST_AW  resend of missing range complete.
- conn_ready_o, msg_ready_o, end_ready_o, done_ready_o  out  1  event accepted when valid&ready.
- req_valid_o / req_type_o / req_host_o  out  1/4/HOST_AW  request to create_message; req_ready_i  in  1.
- disconnect_o / disconnect_host_o  out  1/HOST_AW  close TCP session (1-cycle pulse).
- ignore_o  out  1  message discarded (pulse).
- update_seq_o / update_seq_host_o  out  1/HOST_AW  to sequence generator (pulse).
- resend_o / resend_host_o  out  1/HOST_AW  peer requested resend (pulse).
- state_host_i  in  HOST_AW; state_o  out  3  registered session-state readback, 1-cycle latency.

## Operation
- States: DISC=0, CONN=1, LOGON_SENT=2, NORMAL=3, SENT_HB=4, LOGOUT_SENT=5, SENT_RESEND=6, RESEND_LOGOUT=7.
- One event accepted per cycle. Priority: connect > message > end > done > timeout service. All readys are 0 when the FIFO has no free slot; otherwise only the highest-priority pending valid sees ready=1. Each event enqueues at most one request.
- Connect (any state, reinitialises): initiator → enqueue logon, LOGON_SENT; acceptor → CONN.
- Message, any non-DISC state: msgSeqL/invalid → disconnect, DISC. garbled → ignore_o, no change. Message to DISC host → ignore_o.
- CONN: logon valid → enqueue logon, NORMAL; otherwise disconnect, DISC.
- LOGON_SENT: logon valid → NORMAL; logon msgSeqH → enqueue resendReq, SENT_RESEND; otherwise disconnect, DISC.
- NORMAL/SENT_HB, checked in order: logout msgSeqH → resendReq, RESEND_LOGOUT; logout valid → enqueue logout, DISC; resendReq → resend_o, NORMAL; other msgSeqH → resendReq, SENT_RESEND; otherwise → NORMAL.
- SENT_RESEND/RESEND_LOGOUT: gapFill or reset → update_seq_o; other msgSeqH → resendReq; state unchanged.
- LOGOUT_SENT: logout → disconnect, DISC; other → ignore_o.
- End: NORMAL/SENT_HB → enqueue logout, LOGOUT_SENT; other states → accepted, no action.
- Done: SENT_RESEND → NORMAL; RESEND_LOGOUT → enqueue logout, LOGOUT_SENT; other states → no action.
- Timers: per-host counter runs while state≠DISC. Cleared on any accepted event for that host, on any state change and on timeout service. On reaching HB_CYCLES it sets a sticky expiry flag and holds.
- Timeout service: a round-robin pointer advances one host per cycle when no event is accepted. If the pointed host has expiry set and the FIFO has space, service it and clear the flag:
  - CONN/LOGON_SENT/LOGOUT_SENT/SENT_HB → disconnect, DISC.
  - NORMAL → enqueue heartbeat, SENT_HB.
  - SENT_RESEND/RESEND_LOGOUT → enqueue heartbeat, state unchanged.
- FIFO: standard valid/ready. No enqueue when full, so requests are never dropped.

## Timing
- Reset: all outputs 0, all states DISC, timers/flags 0, FIFO empty, pointer 0. readys go to 1 on the first cycle after reset deasserts.
- Readys are combinational from the valids and FIFO count; all other outputs are registered.
- Event accepted at edge N → pulses, state update and FIFO write at N+1. req_valid_o is high at N+1 if the FIFO was empty.
- Pop at valid&ready. Simultaneous push and pop allowed when not full.
- Reset mid-operation flushes the FIFO and all sessions.

## Test plan
- Host 2 connect, initiator=1 → req logon host 2; peer logon valid → state_o=3 (NORMAL).
- Host 5 acceptor: connect, then logon valid → req logon host 5, NORMAL; bad first message → disconnect_o host 5, state 0.
- NORMAL, no traffic, HB_CYCLES=16 → heartbeat req ~16 cycles later, state 4. A second expiry → disconnect, state 0.
- NORMAL: msgSeqH heartbeat → resendReq, state 6; gapFill → update_seq_o; resend_done → state 3. Logout msgSeqH then resend_done → logout req, state 5.
- req_ready_i=0 with 4 connects → FIFO full, all readys 0. Connect and message pending together → connect accepted first.
- rst asserted with 3 requests queued → req_valid_o=0 immediately, every state_o reads 0.
